// File: rtl/cc_ben_unit.sv
// cc_ben_unit: registered NZP condition codes and branch enable,
// with an NZP save stack for interrupt entry and RTI.
module cc_ben_unit #(
    parameter int WIDTH  = 16,
    parameter bit SIGNED = 1'b1,
    parameter int DEPTH  = 4,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic [WIDTH-1:0] bus_data,
    input  logic             ld_cc,
    input  logic             ld_ben,
    input  logic [2:0]       ir_nzp,
    input  logic             push,
    input  logic             pop,
    input  logic             clr_err,
    output logic             n,
    output logic             z,
    output logic             p,
    output logic             ben,
    output logic [CW-1:0]    stk_cnt,
    output logic             stk_full,
    output logic             stk_empty,
    output logic             ovf_err,
    output logic             unf_err
);

    localparam logic [CW-1:0] DepthC = CW'(DEPTH);
    localparam logic [CW-1:0] OneC   = CW'(1);
    localparam logic [2:0]    NzpZ   = 3'b010;

    logic [2:0]    nzp_q, nzp_d;
    logic          ben_q, ben_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ovf_q, ovf_d;
    logic          unf_q, unf_d;
    logic [2:0]    stack_q [DEPTH];

    logic [2:0] bus_nzp;
    logic [2:0] top_nzp;
    logic       full;
    logic       empty;
    logic       do_push;
    logic       do_pop;
    logic       ovf_set;
    logic       unf_set;

    assign full  = (cnt_q == DepthC);
    assign empty = (cnt_q == '0);

    // A simultaneous push and pop cancels out and touches no stack state.
    assign do_push = push & ~pop & ~full;
    assign do_pop  = pop & ~push & ~empty;
    assign ovf_set = push & ~pop & full;
    assign unf_set = pop & ~push & empty;

    // Decode the bus value into a one-hot NZP code.
    always_comb begin
        bus_nzp = 3'b001;
        if (bus_data == '0) begin
            bus_nzp = NzpZ;
        end else if (SIGNED && bus_data[WIDTH-1]) begin
            bus_nzp = 3'b100;
        end
    end

    // Select the entry on top of the stack (index cnt-1).
    always_comb begin
        top_nzp = NzpZ;
        for (int i = 0; i < DEPTH; i++) begin
            if (CW'(i) == cnt_q - OneC) begin
                top_nzp = stack_q[i];
            end
        end
    end

    // Next-state for codes, branch enable, occupancy and error flags.
    always_comb begin
        nzp_d = nzp_q;
        ben_d = ben_q;
        cnt_d = cnt_q;
        ovf_d = ovf_q & ~clr_err;
        unf_d = unf_q & ~clr_err;

        if (do_pop) begin
            nzp_d = top_nzp;
        end else if (ld_cc) begin
            nzp_d = bus_nzp;
        end

        // BEN always evaluates against the pre-edge codes.
        if (ld_ben) begin
            ben_d = |(ir_nzp & nzp_q);
        end

        if (do_push) begin
            cnt_d = cnt_q + OneC;
        end else if (do_pop) begin
            cnt_d = cnt_q - OneC;
        end

        if (ovf_set) begin
            ovf_d = 1'b1;
        end
        if (unf_set) begin
            unf_d = 1'b1;
        end
    end

    // Control and status registers with asynchronous reset.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            nzp_q <= NzpZ;
            ben_q <= 1'b0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            nzp_q <= nzp_d;
            ben_q <= ben_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    // Stack storage is not reset; occupancy alone defines valid entries.
    always_ff @(posedge Clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (do_push && (cnt_q == CW'(i))) begin
                stack_q[i] <= nzp_q;
            end
        end
    end

    assign n         = nzp_q[2];
    assign z         = nzp_q[1];
    assign p         = nzp_q[0];
    assign ben       = ben_q;
    assign stk_cnt   = cnt_q;
    assign stk_full  = full;
    assign stk_empty = empty;
    assign ovf_err   = ovf_q;
    assign unf_err   = unf_q;

endmodule

// File: tb/tb_cc_ben_unit.sv
// tb_cc_ben_unit: directed checks of the NZP/BEN unit,
// signed and unsigned decode, save stack and async reset.
module tb_cc_ben_unit;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic [15:0] bus_data = '0;
    logic        ld_cc = 1'b0;
    logic        ld_ben = 1'b0;
    logic [2:0]  ir_nzp = '0;
    logic        push = 1'b0;
    logic        pop = 1'b0;
    logic        clr_err = 1'b0;

    logic       n, z, p, ben;
    logic [2:0] stk_cnt;
    logic       stk_full, stk_empty, ovf_err, unf_err;

    logic       un, uz, up, uben;
    logic [2:0] ucnt;
    logic       ufull, uempty, uovf, uunf;

    int errors = 0;
    int checks = 0;

    always #5 Clk = ~Clk;

    cc_ben_unit #(.WIDTH(16), .SIGNED(1'b1), .DEPTH(4)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .bus_data(bus_data),
        .ld_cc(ld_cc), .ld_ben(ld_ben), .ir_nzp(ir_nzp),
        .push(push), .pop(pop), .clr_err(clr_err),
        .n(n), .z(z), .p(p), .ben(ben), .stk_cnt(stk_cnt),
        .stk_full(stk_full), .stk_empty(stk_empty),
        .ovf_err(ovf_err), .unf_err(unf_err)
    );

    cc_ben_unit #(.WIDTH(16), .SIGNED(1'b0), .DEPTH(4)) u_uns (
        .Clk(Clk), .Reset_n(Reset_n), .bus_data(bus_data),
        .ld_cc(ld_cc), .ld_ben(ld_ben), .ir_nzp(ir_nzp),
        .push(push), .pop(pop), .clr_err(clr_err),
        .n(un), .z(uz), .p(up), .ben(uben), .stk_cnt(ucnt),
        .stk_full(ufull), .stk_empty(uempty),
        .ovf_err(uovf), .unf_err(uunf)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle();
        ld_cc = 0; ld_ben = 0; push = 0; pop = 0; clr_err = 0;
    endtask

    initial begin
        #12;
        chk("rst_nzp", {n, z, p}, 3'b010);
        chk("rst_ben", ben, 0);
        chk("rst_cnt", stk_cnt, 0);
        chk("rst_empty", stk_empty, 1);
        chk("rst_full", stk_full, 0);
        chk("rst_err", {ovf_err, unf_err}, 0);
        Reset_n = 1'b1;
        tick();

        ld_cc = 1; bus_data = 16'h0000; tick();
        chk("dec_0000", {n, z, p}, 3'b010);
        bus_data = 16'h8001; tick();
        chk("dec_8001", {n, z, p}, 3'b100);
        bus_data = 16'h7FFF; tick();
        chk("dec_7fff", {n, z, p}, 3'b001);
        bus_data = 16'h8000; tick();
        chk("uns_8000", {un, uz, up}, 3'b001);
        chk("sgn_8000", {n, z, p}, 3'b100);
        bus_data = 16'h0000; tick();
        chk("uns_0000", {un, uz, up}, 3'b010);

        bus_data = 16'h8000; tick();
        idle();
        ld_ben = 1; ir_nzp = 3'b100; ld_cc = 1; bus_data = 16'h0001;
        tick();
        chk("ben_old_nzp", ben, 1);
        chk("nzp_after_ld", {n, z, p}, 3'b001);
        idle();
        ld_ben = 1; ir_nzp = 3'b110; tick();
        chk("ben_miss", ben, 0);
        idle(); tick();
        chk("ben_hold", ben, 0);

        ld_cc = 1; bus_data = 16'h8000; tick();
        push = 1; bus_data = 16'h0001; tick();
        chk("push1_nzp", {n, z, p}, 3'b001);
        bus_data = 16'h0000; tick();
        bus_data = 16'h0001; tick();
        ld_cc = 0; tick();
        chk("full_cnt", stk_cnt, 4);
        chk("full_flag", stk_full, 1);
        tick();
        chk("ovf_set", ovf_err, 1);
        chk("ovf_cnt", stk_cnt, 4);
        chk("ovf_nzp", {n, z, p}, 3'b001);
        push = 0; pop = 1; tick();
        chk("pop1", {n, z, p}, 3'b001);
        tick();
        chk("pop2", {n, z, p}, 3'b010);
        tick();
        chk("pop3", {n, z, p}, 3'b001);
        tick();
        chk("pop4", {n, z, p}, 3'b100);
        chk("pop_empty", stk_empty, 1);
        tick();
        chk("unf_set", unf_err, 1);
        chk("unf_nzp", {n, z, p}, 3'b100);
        chk("unf_cnt", stk_cnt, 0);

        clr_err = 1; tick();
        chk("clr_vs_unf", {ovf_err, unf_err}, 2'b01);
        pop = 0; tick();
        chk("clr_both", {ovf_err, unf_err}, 2'b00);

        idle();
        push = 1; ld_cc = 1; bus_data = 16'h0001; tick();
        idle();
        pop = 1; ld_cc = 1; bus_data = 16'h0000; tick();
        chk("pop_wins", {n, z, p}, 3'b100);
        chk("pop_cnt", stk_cnt, 0);
        idle();
        push = 1; tick();
        push = 1; pop = 1; ld_cc = 1; bus_data = 16'h0000; tick();
        chk("pp_cnt", stk_cnt, 1);
        chk("pp_err", {ovf_err, unf_err}, 2'b00);
        chk("pp_ldcc", {n, z, p}, 3'b010);

        idle();
        ld_ben = 1; ir_nzp = 3'b111; tick();
        chk("ben_set", ben, 1);
        idle();
        ld_cc = 1; bus_data = 16'h8000; push = 1;
        #2;
        Reset_n = 1'b0;
        #1;
        chk("arst_nzp", {n, z, p}, 3'b010);
        chk("arst_ben", ben, 0);
        chk("arst_cnt", stk_cnt, 0);
        idle();
        #2;
        Reset_n = 1'b1;
        tick();
        chk("arst_empty", stk_empty, 1);
        chk("arst_nzp2", {n, z, p}, 3'b010);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
